fifo_rd_packer: RTL and testbench
=================================

# fifo_rd_packer

Read-side consumer of the dual-clock asynchronous FIFO, running entirely in the read clock domain. Pops DATASIZE-bit entries from the FIFO read port whenever possible and packs LANES consecutive entries into one wide word. Presents each word on a valid/ready stream, with a flush request that emits a partially filled word plus a lane-keep mask.

## Interface
- DATASIZE, 8, FIFO entry width; must match the FIFO's DATASIZE.
- LANES, 4, entries packed per output word; power of two, 2..16.
- rclk  in  1  read-domain clock, shared with the FIFO read side.
- rrst_n  in  1  reset, asynchronous assert, active-low; same net as the FIFO's rrst_n.
- rempty  in  1  FIFO empty flag, already synchronous to rclk.
- rdata  in  DATASIZE  FIFO read data; valid combinationally whenever rempty=0.
- rinc  out  1  FIFO pop strobe; one entry is consumed per rclk rising edge with rinc=1.
- flush  in  1  single-cycle request to emit the current partial word.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the word when out_valid=1 and out_ready=1 at a rising edge.
- out_data  out  DATASIZE*LANES  packed word; the first-popped entry is in lane 0, bits [DATASIZE-1:0].
- out_keep  out  LANES  per-lane valid mask; all ones for a full word.

## Operation
- Internal state: accumulator acc (LANES-1 lanes), lane counter cnt (0..LANES-1), flush_pend flag, FSM {FILL, FLUSH}, and an output register holding out_data, out_keep and out_valid.
- out_free = !out_valid || out_ready.
- FILL state, rinc = !rempty && !(cnt==LANES-1 && !out_free). rinc is forced to 0 while rrst_n=0 and in the FLUSH state.
- Pop with cnt<LANES-1: acc[cnt] <= rdata and cnt <= cnt+1.
- Pop with cnt==LANES-1: the output register loads {rdata, acc}, out_keep <= all ones, out_valid <= 1, cnt <= 0, and acc is cleared.
- Output register: on handshake without a new load, out_valid <= 0. Load and handshake on the same edge gives back-to-back words with out_valid staying 1.
- flush=1 in any state sets flush_pend. A flush arriving while flush_pend is already set is absorbed and not counted twice.
- FILL -> FLUSH at the edge where flush_pend is set (or flush=1) and no word-completing pop occurs on that edge. If a word completes on that edge, the completed word goes out and the flush then applies to the now-empty accumulator.
- FLUSH with cnt==0: clear flush_pend, return to FILL, emit nothing.
- FLUSH with cnt>0 and out_free: load the output register with acc, zero the unused lanes, set out_keep = (1<<cnt)-1, set out_valid=1, set cnt=0, clear acc and flush_pend, return to FILL.
- FLUSH with cnt>0 and !out_free: hold in FLUSH.
- Arithmetic: cnt wraps modulo LANES and is LANES_W = log2(LANES) bits wide. There is no overflow path, because a pop is blocked whenever completing a word would have nowhere to go.

## Timing
- Reset values: rinc=0, out_valid=0, out_data=0, out_keep=0, cnt=0, acc=0, flush_pend=0, FSM=FILL.
- Reset assertion mid-word discards the partial word and any pending flush immediately.
- Latency: out_valid rises on the same rclk edge that pops the LANES-th entry.
- Flush latency: 2 edges when the output register is free (1 to enter FLUSH, 1 to emit).
- Throughput: 1 entry per cycle. With out_ready held high and the FIFO non-empty, one word every LANES cycles with no bubbles.
- Backpressure: while out_valid=1 and out_ready=0, the block keeps popping until cnt==LANES-1, then stalls with rinc=0. out_data and out_keep stay stable until the handshake.
- rempty=1: rinc=0 and no state change except the flush handling above.

## Structure
- Shared package fifo_pkg holds:
  - DATASIZE and ADDRSIZE defaults, LANES, and LANES_W.
  - The FSM state enum {FILL, FLUSH}.
  - Keep-mask helper constant KEEP_FULL.
- One sub-module: rd_out_reg, the single-entry valid/ready output register. It takes a load strobe plus data/keep and exposes out_free. Accumulator, counter and FSM live in fifo_rd_packer.

## Test plan
- Push 00,FF,F1,F2 into the FIFO with out_ready=1:
  - out_data=32'hF2F1FF00 and out_keep=4'hF for exactly one cycle.
  - rinc is asserted 4 times.
- Stream 00,FF,F1..FE (16 bytes), out_ready=1:
  - 4 words are produced, the first 32'hF2F1FF00 and the last 32'hFEFDFCFB.
  - Words arrive every 4 cycles once the FIFO is non-empty.
- Hold out_ready=0 with 8 bytes queued:
  - The first word is held stable.
  - rinc drops after the 7th pop (cnt==3).
  - Releasing out_ready yields the second word on the next edge.
- Write F3,F4,F5, wait for rempty=1, pulse flush:
  - 2 edges later out_data=32'h00F5F4F3 and out_keep=4'b0111.
  - A flush with cnt==0 produces no output.
- Pulse flush on the same edge as the 4th pop of A1,A2,A3,A4:
  - A full word 32'hA4A3A2A1 with keep 4'hF.
  - No extra empty word.
- Assert rrst_n=0 after 2 of 4 bytes have been popped:
  - All outputs go to 0 asynchronously.
  - After release the next 4 bytes form a clean word in lane order.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and types for the read-side FIFO consumer.
// LANES_W sizes the lane counter; KEEP_FULL is the keep mask of a complete word.
package fifo_pkg;

  localparam int DATASIZE = 8;
  localparam int ADDRSIZE = 4;
  localparam int LANES    = 4;
  localparam int LANES_W  = $clog2(LANES);

  localparam logic [LANES-1:0] KEEP_FULL = {LANES{1'b1}};

  typedef enum logic {
    FILL  = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/rd_out_reg.sv
// Single-entry valid/ready output register.
// A load always wins over a handshake, so back-to-back words keep valid high.
module rd_out_reg #(
  parameter int DW = 32,
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic [KW-1:0] keep_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic [KW-1:0] keep_o,
  output logic          free_o
);

  logic          valid_q;
  logic [DW-1:0] data_q;
  logic [KW-1:0] keep_q;

  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign keep_o  = keep_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      keep_q  <= keep_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops FIFO entries and packs LANES of them into one wide word, first-popped in lane 0.
// A flush request emits the partial word with a lane-keep mask.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DATASIZE = fifo_pkg::DATASIZE,
  parameter int LANES    = fifo_pkg::LANES
) (
  input  logic                      rclk,
  input  logic                      rrst_n,
  input  logic                      rempty,
  input  logic [DATASIZE-1:0]       rdata,
  output logic                      rinc,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATASIZE*LANES-1:0] out_data,
  output logic [LANES-1:0]          out_keep
);

  localparam int CW = $clog2(LANES);
  localparam int W  = DATASIZE * LANES;
  localparam int AW = DATASIZE * (LANES - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LANES - 1);

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic [AW-1:0]         acc_q;
  logic                  flush_pend_q;

  logic                  out_free;
  logic                  cnt_last;
  logic                  cnt_zero;
  logic                  word_done;
  logic                  flush_req;
  logic                  flush_emit;
  logic                  load;
  logic [W-1:0]          load_data;
  logic [LANES-1:0]      load_keep;
  logic [LANES-1:0]      part_keep;
  logic [W-1:0]          part_data;

  assign cnt_last = (cnt_q == CNT_LAST);
  assign cnt_zero = (cnt_q == '0);

  // Completing a word is only allowed when the output register can take it.
  assign rinc       = rrst_n && (state_q == FILL) && !rempty && !(cnt_last && !out_free);
  assign word_done  = rinc && cnt_last;
  assign flush_req  = flush_pend_q || flush;
  assign flush_emit = (state_q == FLUSH) && !cnt_zero && out_free;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign part_keep[gi] = (CW'(gi) < cnt_q);
      if (gi < LANES - 1) begin : g_acc
        assign part_data[gi*DATASIZE +: DATASIZE] =
          acc_q[gi*DATASIZE +: DATASIZE] & {DATASIZE{part_keep[gi]}};
      end else begin : g_top
        assign part_data[gi*DATASIZE +: DATASIZE] = '0;
      end
    end
  endgenerate

  assign load      = word_done || flush_emit;
  assign load_data = word_done ? {rdata, acc_q} : part_data;
  assign load_keep = word_done ? {LANES{1'b1}} : part_keep;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      acc_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (rinc) begin
            if (cnt_last) begin
              cnt_q <= '0;
              acc_q <= '0;
            end else begin
              for (int i = 0; i < LANES - 1; i++) begin
                if (cnt_q == CW'(i)) acc_q[i*DATASIZE +: DATASIZE] <= rdata;
              end
              cnt_q <= cnt_q + CW'(1);
            end
          end
          // A word completing on this edge empties the accumulator; the flush stays pending.
          if (flush_req) begin
            flush_pend_q <= 1'b1;
            if (!word_done) state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (cnt_zero) begin
            flush_pend_q <= 1'b0;
            state_q      <= FILL;
          end else if (out_free) begin
            cnt_q        <= '0;
            acc_q        <= '0;
            flush_pend_q <= 1'b0;
            state_q      <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  rd_out_reg #(
    .DW(W),
    .KW(LANES)
  ) u_out_reg (
    .clk     (rclk),
    .rst_n   (rrst_n),
    .load_i  (load),
    .data_i  (load_data),
    .keep_i  (load_keep),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .data_o  (out_data),
    .keep_o  (out_keep),
    .free_o  (out_free)
  );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a queue-based FIFO/word model checked every cycle,
// directed scenarios pinned with literal words, then a randomized run.
module tb_fifo_rd_packer;

  localparam int D = 8;
  localparam int L = 4;
  localparam int W = D * L;

  logic         rclk = 1'b0;
  logic         rrst_n = 1'b1;
  logic         rempty = 1'b1;
  logic [D-1:0] rdata = '0;
  logic         rinc;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [L-1:0] out_keep;

  always #5 rclk = ~rclk;

  fifo_rd_packer #(
    .DATASIZE(D),
    .LANES   (L)
  ) dut (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .rempty   (rempty),
    .rdata    (rdata),
    .rinc     (rinc),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_keep (out_keep)
  );

  // Model: FIFO contents, entries gathered toward the current word, output slot.
  logic [D-1:0] fq[$];
  logic [D-1:0] accm[$];
  bit           pend_m, fmode_m, vm;
  logic [W-1:0] dm;
  logic [L-1:0] km;

  logic [W-1:0] got[$];
  logic [L-1:0] gotk[$];
  int           hs_cyc[$];

  int tests = 0, fails = 0;
  int n_rinc = 0, n_valid = 0, cyc_no = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc_no);
    end
  endtask

  task automatic clear_stats();
    n_rinc = 0;
    n_valid = 0;
    got.delete();
    gotk.delete();
    hs_cyc.delete();
  endtask

  task automatic model_edge(input bit fl, input bit rdy, input bit popped);
    logic [W-1:0] nd;
    logic [L-1:0] nk;
    bit ld, done;
    ld = 0; done = 0; nd = '0; nk = '0;
    if (vm && rdy) begin
      got.push_back(dm);
      gotk.push_back(km);
      hs_cyc.push_back(cyc_no);
      $display("[TB] word %0d: data=%08h keep=%b cycle=%0d", got.size() - 1, dm, km, cyc_no);
    end
    if (!fmode_m) begin
      if (popped) accm.push_back(fq.pop_front());
      if (accm.size() == L) begin
        done = 1; ld = 1;
        for (int i = 0; i < L; i++) nd[i*D +: D] = accm[i];
        nk = '1;
        accm.delete();
      end
      if (pend_m || fl) begin
        pend_m = 1;
        if (!done) fmode_m = 1;
      end
    end else if (accm.size() == 0) begin
      pend_m = 0; fmode_m = 0;
    end else if (!vm || rdy) begin
      ld = 1;
      for (int i = 0; i < accm.size(); i++) nd[i*D +: D] = accm[i];
      nk = L'((1 << accm.size()) - 1);
      accm.delete();
      pend_m = 0; fmode_m = 0;
    end
    if (ld) begin
      vm = 1; dm = nd; km = nk;
    end else if (vm && rdy) begin
      vm = 0;
    end
  endtask

  // One rclk cycle, entered and left just after a falling edge.
  task automatic cyc(input bit fl);
    bit exp_rinc;
    flush  = fl;
    rempty = (fq.size() == 0);
    rdata  = (fq.size() != 0) ? fq[0] : D'($urandom);
    #1;
    exp_rinc = !fmode_m && (fq.size() != 0) && !(accm.size() == L - 1 && vm && !out_ready);
    check("rinc", rinc, exp_rinc);
    if (rinc) n_rinc++;
    @(posedge rclk);
    model_edge(fl, out_ready, exp_rinc);
    #1;
    cyc_no++;
    check("out_valid", out_valid, vm);
    if (vm) begin
      check("out_data", out_data, dm);
      check("out_keep", out_keep, km);
    end
    if (out_valid) n_valid++;
    @(negedge rclk);
    flush = 1'b0;
  endtask

  // Asserts reset mid-cycle; the FIFO shares the reset net so it empties too.
  task automatic do_reset();
    #2 rrst_n = 1'b0;
    #1;
    check("rst_rinc", rinc, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_keep", out_keep, 0);
    fq.delete(); accm.delete();
    pend_m = 0; fmode_m = 0; vm = 0; dm = '0; km = '0;
    flush = 1'b0;
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // Single word
    clear_stats();
    out_ready = 1'b1;
    fq.push_back(8'h00); fq.push_back(8'hFF); fq.push_back(8'hF1); fq.push_back(8'hF2);
    repeat (8) cyc(0);
    check("t1_nwords", got.size(), 1);
    if (got.size() > 0) begin
      check("t1_word", got[0], 32'hF2F1FF00);
      check("t1_keep", gotk[0], 4'hF);
    end
    check("t1_rinc_count", n_rinc, 4);
    check("t1_valid_cycles", n_valid, 1);

    // 16-byte stream
    clear_stats();
    fq.push_back(8'h00); fq.push_back(8'hFF);
    for (int b = 8'hF1; b <= 8'hFE; b++) fq.push_back(D'(b));
    repeat (20) cyc(0);
    check("t2_nwords", got.size(), 4);
    if (got.size() == 4) begin
      check("t2_first", got[0], 32'hF2F1FF00);
      check("t2_last", got[3], 32'hFEFDFCFB);
      for (int i = 1; i < 4; i++) check("t2_spacing", hs_cyc[i] - hs_cyc[i-1], 4);
    end

    // Backpressure
    clear_stats();
    out_ready = 1'b0;
    for (int b = 8'h10; b <= 8'h17; b++) fq.push_back(D'(b));
    repeat (4) cyc(0);
    check("t3_first_valid", out_valid, 1);
    repeat (5) begin
      cyc(0);
      check("t3_hold", out_data, 32'h13121110);
    end
    check("t3_rinc_count", n_rinc, 7);
    check("t3_stall", rinc, 0);
    out_ready = 1'b1;
    cyc(0);
    check("t3_second_valid", out_valid, 1);
    check("t3_second", out_data, 32'h17161514);
    cyc(0);
    check("t3_nwords", got.size(), 2);

    // Partial flush, then an empty flush
    clear_stats();
    fq.push_back(8'hF3); fq.push_back(8'hF4); fq.push_back(8'hF5);
    repeat (4) cyc(0);
    cyc(1);
    cyc(0);
    check("t4_valid", out_valid, 1);
    check("t4_data", out_data, 32'h00F5F4F3);
    check("t4_keep", out_keep, 4'b0111);
    cyc(0);
    n_valid = 0;
    cyc(1);
    repeat (4) cyc(0);
    check("t4_empty_flush", n_valid, 0);

    // Flush on the word-completing pop
    clear_stats();
    fq.push_back(8'hA1); fq.push_back(8'hA2); fq.push_back(8'hA3); fq.push_back(8'hA4);
    repeat (3) cyc(0);
    cyc(1);
    check("t5_data", out_data, 32'hA4A3A2A1);
    check("t5_keep", out_keep, 4'hF);
    repeat (5) cyc(0);
    check("t5_nwords", got.size(), 1);
    check("t5_valid_cycles", n_valid, 1);

    // Reset mid-word with a held output word
    clear_stats();
    out_ready = 1'b0;
    for (int b = 8'h20; b <= 8'h25; b++) fq.push_back(D'(b));
    repeat (6) cyc(0);
    do_reset();
    clear_stats();
    out_ready = 1'b1;
    fq.push_back(8'hC1); fq.push_back(8'hC2); fq.push_back(8'hC3); fq.push_back(8'hC4);
    repeat (6) cyc(0);
    check("t6_nwords", got.size(), 1);
    if (got.size() > 0) begin
      check("t6_word", got[0], 32'hC4C3C2C1);
      check("t6_keep", gotk[0], 4'hF);
    end

    // Randomized traffic against the model
    clear_stats();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if (($urandom % 3) != 0 && fq.size() < 10) fq.push_back(D'($urandom));
      out_ready = (($urandom % 4) != 0);
      cyc(($urandom % 12) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
